// File: rtl/mem_responder.sv
// 32x8 memory responder: IDLE/ACCESS/DONE handshake with WAIT_STATES extra access cycles.
// Optional MEM_PARITY_EN adds an even-parity bit per word and a parity-error flag on reads.
module mem_responder #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       read,
    input  logic       write,
    input  logic [4:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       busy,
    output logic       err,
    output logic       perr
);

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = 3;
    localparam int unsigned DEPTH = 32;
`ifdef MEM_PARITY_EN
    localparam int unsigned MW    = DW + 1;
`else
    localparam int unsigned MW    = DW;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            op_rd_q, op_rd_d;
    logic            op_wr_q, op_wr_d;
    logic [DW-1:0]   data_out_q, data_out_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic            perr_q, perr_d;

    logic [MW-1:0]   mem_q [DEPTH];
    logic [MW-1:0]   wword_c;
    logic [MW-1:0]   rword_c;
    logic            mem_we_c;
    logic            rd_bad_c;

    // Stored word format: parity (if enabled) above the data byte
`ifdef MEM_PARITY_EN
    assign wword_c  = {^wdata_q, wdata_q};
    assign rd_bad_c = ^rword_c;
`else
    assign wword_c  = wdata_q;
    assign rd_bad_c = 1'b0;
`endif
    assign rword_c = mem_q[addr_q];

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_rd_d    = op_rd_q;
        op_wr_d    = op_wr_q;
        data_out_d = data_out_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        perr_d     = 1'b0;
        mem_we_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (read || write) begin
                    state_d = ACCESS;
                    cnt_d   = CW'(WAIT_STATES);
                    addr_d  = addr;
                    wdata_d = data_in;
                    op_rd_d = read;
                    op_wr_d = write;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    err_d   = op_rd_q && op_wr_q;
                    if (op_rd_q && !op_wr_q) begin
                        data_out_d = rword_c[DW-1:0];
                        perr_d     = rd_bad_c;
                    end
                    mem_we_c = op_wr_q && !op_rd_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_rd_q    <= 1'b0;
            op_wr_q    <= 1'b0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            op_rd_q    <= op_rd_d;
            op_wr_q    <= op_wr_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            perr_q     <= perr_d;
        end
    end

    // Storage is not reset; an asserted reset blocks any in-flight commit
    always_ff @(posedge clk) begin
        if (mem_we_c && !rst) begin
            mem_q[addr_q] <= wword_c;
        end
    end

    assign data_out = data_out_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign perr     = perr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: scoreboard of expected completions checked on each ready pulse.
// Parity-corruption step is built only when MEM_PARITY_EN is defined.
module tb_mem_responder;

    localparam int unsigned WS = 1;

    logic       clk;
    logic       rst;
    logic       read;
    logic       write;
    logic [4:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       ready;
    logic       busy;
    logic       err;
    logic       perr;

    mem_responder #(.WAIT_STATES(WS)) dut (
        .clk      (clk),
        .rst      (rst),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ready    (ready),
        .busy     (busy),
        .err      (err),
        .perr     (perr)
    );

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic       perr;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] model_mem [32];
    logic [7:0] exp_dout;
    int         checks;
    int         failures;
    int         ready_cnt;
    int         err_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (ready === 1'b1) ready_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request: drive in IDLE, optionally scramble inputs while busy, check on ready
    task automatic do_req(input logic rd, input logic wr, input logic [4:0] a,
                          input logic [7:0] d, input logic noisy, input logic exp_perr);
        exp_t e;
        int   n;
        @(negedge clk);
        check("busy_idle", 32'(busy), 32'd0);
        read    = rd;
        write   = wr;
        addr    = a;
        data_in = d;
        e.err   = rd && wr;
        e.perr  = exp_perr;
        if (rd && !wr) exp_dout = model_mem[a];
        else if (wr && !rd) model_mem[a] = d;
        e.data  = exp_dout;
        sb.push_back(e);
        @(posedge clk);
        n = 0;
        #1;
        read  = noisy;
        write = noisy;
        while (n < 20) begin
            if (noisy) begin
                addr    = 5'($urandom);
                data_in = 8'($urandom);
            end
            @(posedge clk);
            n++;
            #1;
            if (ready === 1'b1) break;
            check("busy_access", 32'(busy), 32'd1);
        end
        read  = 1'b0;
        write = 1'b0;
        check("ready_latency", 32'(n), 32'(WS + 1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("data_out", 32'(data_out), 32'(e.data));
            check("err", 32'(err), 32'(e.err));
            check("perr", 32'(perr), 32'(e.perr));
        end
        check("busy_done", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("ready_pulse_end", 32'(ready), 32'd0);
        check("err_pulse_end", 32'(err), 32'd0);
        check("busy_back_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int rc0;
        int ec0;
        checks    = 0;
        failures  = 0;
        ready_cnt = 0;
        err_cnt   = 0;
        exp_dout  = 8'h00;
        rst       = 1'b1;
        read      = 1'b0;
        write     = 1'b0;
        addr      = '0;
        data_in   = '0;

        // Reset state
        #12;
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_perr", 32'(perr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Clear test
        rc0 = ready_cnt;
        ec0 = err_cnt;
        for (int i = 0; i < 32; i++) do_req(1'b0, 1'b1, 5'(i), 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) do_req(1'b1, 1'b0, 5'(i), 8'hEE, 1'b0, 1'b0);
        check("clear_ready_count", 32'(ready_cnt - rc0), 32'd64);
        check("clear_err_count", 32'(err_cnt - ec0), 32'd0);

        // Data equals address
        for (int i = 0; i < 32; i++) do_req(1'b0, 1'b1, 5'(i), 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) do_req(1'b1, 1'b0, 5'(i), 8'h00, 1'b0, 1'b0);

        // Collision
        do_req(1'b0, 1'b1, 5'd3, 8'hA5, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0);
        do_req(1'b1, 1'b1, 5'd3, 8'h5A, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0);

        // Reset mid-write
        do_req(1'b0, 1'b1, 5'd7, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        read    = 1'b0;
        write   = 1'b1;
        addr    = 5'd7;
        data_in = 8'hFF;
        @(posedge clk);
        #1;
        write = 1'b0;
        check("abort_in_access", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_data_out", 32'(data_out), 32'h00);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        check("abort_perr", 32'(perr), 32'd0);
        exp_dout = 8'h00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b1, 1'b0, 5'd7, 8'h00, 1'b0, 1'b0);

        // Ignore-while-busy: inputs scrambled during ACCESS
        do_req(1'b1, 1'b0, 5'd5, 8'h00, 1'b1, 1'b0);
        do_req(1'b0, 1'b1, 5'd9, 8'h99, 1'b1, 1'b0);
        do_req(1'b1, 1'b0, 5'd9, 8'h00, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 5'd5, 8'h00, 1'b0, 1'b0);

        // Write then read, same address
        do_req(1'b0, 1'b1, 5'd31, 8'hC3, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 5'd31, 8'h00, 1'b0, 1'b0);

`ifdef MEM_PARITY_EN
        do_req(1'b0, 1'b1, 5'd2, 8'h3C, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 5'd2, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        dut.mem_q[2][8] = ~dut.mem_q[2][8];
        do_req(1'b1, 1'b0, 5'd2, 8'h00, 1'b0, 1'b1);
        do_req(1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0);
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
